// File: rtl/manchester_codec.sv
// manchester_codec: Manchester write encoder and read decoder sharing one clock.
//
// Encoder: accepts a WORD_W-bit word on a tx_valid/tx_ready handshake and
// drives one frame on the head lines. A frame is a start bit (1) followed by
// the data bits, MSB first. Each bit cell is HALF_BIT cycles of !b followed by
// HALF_BIT cycles of b. After the frame the line idles for 2*HALF_BIT cycles
// before the next word is accepted.
// Decoder: synchronizes rd_in and waits for a rising edge (mid start bit).
// It then samples both halves of every data bit cell. A cell whose two halves
// match marks the frame as errored.
//
// Ports:
//   clk       in   system clock, all state changes on its rising edge
//   rst       in   synchronous active-high reset
//   tx_data   in   [WORD_W] word to send, MSB first
//   tx_valid  in   write request
//   tx_ready  out  encoder idle and able to accept a word
//   wr_p      out  head drive, true polarity
//   wr_n      out  head drive, always the complement of wr_p
//   wr_gate   out  write-current enable, high while a frame is driven
//   rd_in     in   raw read signal, asynchronous to clk
//   rx_data   out  [WORD_W] last good decoded word
//   rx_valid  out  one-cycle pulse for a good frame
//   rx_err    out  one-cycle pulse for a frame with a bit-cell error
module manchester_codec #(
  parameter int WORD_W   = 8,
  parameter int HALF_BIT = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              wr_p,
  output logic              wr_n,
  output logic              wr_gate,
  input  logic              rd_in,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err
);

  // One counter width covers a half cell, the 2*HALF_BIT gap and the
  // 1.5*HALF_BIT first decoder wait.
  localparam int CW = $clog2(2 * HALF_BIT) + 1;
  localparam int BW = $clog2(WORD_W + 1) + 1;

  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(2 * HALF_BIT - 1);
  localparam logic [CW-1:0] FIRST_WAIT = CW'(HALF_BIT + HALF_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_ONE    = BW'(1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(WORD_W);

  typedef enum logic [1:0] {IDLE, SEND, GAP} tx_state_t;
  typedef enum logic [1:0] {RIDLE, RBITS, RDONE} rx_state_t;

  tx_state_t         tx_state_r;
  logic [WORD_W:0]   tx_sh_r;     // MSB is the bit currently on the line
  logic [CW-1:0]     tx_cyc_r;
  logic              tx_half_r;
  logic [BW-1:0]     tx_bit_r;    // 0 = start bit, 1..WORD_W = data bits

  logic              sync1_r;
  logic              rd_s;
  logic              rd_d_r;
  logic [1:0]        fill_r;
  logic              low_seen_r;
  logic              rd_rise_s;

  rx_state_t         rx_state_r;
  logic [CW-1:0]     rx_cnt_r;
  logic [BW-1:0]     rx_bit_r;
  logic              rx_phase_r;  // 0 = next sample is first half, 1 = second half
  logic              rx_a_r;
  logic              rx_bad_r;
  logic [WORD_W-1:0] rx_sh_r;
  logic [WORD_W-1:0] rx_next_s;

  // Encoder FSM with registered line outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_r <= IDLE;
      tx_sh_r    <= '0;
      tx_cyc_r   <= '0;
      tx_half_r  <= 1'b0;
      tx_bit_r   <= '0;
      tx_ready   <= 1'b1;
      wr_p       <= 1'b0;
      wr_n       <= 1'b1;
      wr_gate    <= 1'b0;
    end else begin
      case (tx_state_r)
        IDLE: begin
          if (tx_valid) begin
            tx_state_r <= SEND;
            tx_sh_r    <= {1'b1, tx_data};
            tx_cyc_r   <= '0;
            tx_half_r  <= 1'b0;
            tx_bit_r   <= '0;
            tx_ready   <= 1'b0;
            wr_p       <= 1'b0;   // first half of the start bit is !1
            wr_n       <= 1'b1;
            wr_gate    <= 1'b1;
          end
        end
        SEND: begin
          if (tx_cyc_r == HALF_LAST) begin
            tx_cyc_r <= '0;
            if (!tx_half_r) begin
              tx_half_r <= 1'b1;
              wr_p      <= tx_sh_r[WORD_W];
              wr_n      <= ~tx_sh_r[WORD_W];
            end else if (tx_bit_r == LAST_BIT) begin
              tx_state_r <= GAP;
              tx_half_r  <= 1'b0;
              wr_p       <= 1'b0;
              wr_n       <= 1'b1;
              wr_gate    <= 1'b0;
            end else begin
              tx_half_r <= 1'b0;
              tx_bit_r  <= tx_bit_r + BIT_ONE;
              tx_sh_r   <= tx_sh_r << 1'b1;
              wr_p      <= ~tx_sh_r[WORD_W-1];
              wr_n      <= tx_sh_r[WORD_W-1];
            end
          end else begin
            tx_cyc_r <= tx_cyc_r + CNT_ONE;
          end
        end
        GAP: begin
          if (tx_cyc_r == GAP_LAST) begin
            tx_state_r <= IDLE;
            tx_cyc_r   <= '0;
            tx_ready   <= 1'b1;
          end else begin
            tx_cyc_r <= tx_cyc_r + CNT_ONE;
          end
        end
        default: begin
          tx_state_r <= IDLE;
          tx_cyc_r   <= '0;
          tx_ready   <= 1'b1;
          wr_p       <= 1'b0;
          wr_n       <= 1'b1;
          wr_gate    <= 1'b0;
        end
      endcase
    end
  end

  // Read synchronizer plus arming logic. The reset zeros in the synchronizer
  // are not real line samples, so a rising edge only counts once a genuine
  // low has been seen after the pipeline has filled.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r    <= 1'b0;
      rd_s       <= 1'b0;
      rd_d_r     <= 1'b0;
      fill_r     <= 2'd0;
      low_seen_r <= 1'b0;
    end else begin
      sync1_r <= rd_in;
      rd_s    <= sync1_r;
      rd_d_r  <= rd_s;
      if (fill_r != 2'd2) begin
        fill_r <= fill_r + 2'd1;
      end
      if ((fill_r == 2'd2) && !rd_s) begin
        low_seen_r <= 1'b1;
      end
    end
  end

  // Rising edge of the synchronized line and the next decoded-word value.
  always_comb begin
    rd_rise_s = low_seen_r & ~rd_d_r & rd_s;
    rx_next_s = (rx_sh_r << 1'b1) | WORD_W'(rd_s);
  end

  // Decoder FSM: all samples are HALF_BIT apart, the first one 1.5 half
  // cells after the mid-start-bit edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_r <= RIDLE;
      rx_cnt_r   <= '0;
      rx_bit_r   <= '0;
      rx_phase_r <= 1'b0;
      rx_a_r     <= 1'b0;
      rx_bad_r   <= 1'b0;
      rx_sh_r    <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_err     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      case (rx_state_r)
        RIDLE: begin
          if (rd_rise_s) begin
            rx_state_r <= RBITS;
            rx_cnt_r   <= FIRST_WAIT;
            rx_bit_r   <= BIT_ONE;
            rx_phase_r <= 1'b0;
            rx_bad_r   <= 1'b0;
          end
        end
        RBITS: begin
          if (rx_cnt_r == '0) begin
            rx_cnt_r <= HALF_LAST;
            if (!rx_phase_r) begin
              rx_a_r     <= rd_s;
              rx_phase_r <= 1'b1;
            end else begin
              rx_phase_r <= 1'b0;
              rx_sh_r    <= rx_next_s;
              if (rx_a_r == rd_s) begin
                rx_bad_r <= 1'b1;
              end
              if (rx_bit_r == LAST_BIT) begin
                // Pulses become visible together with RDONE.
                rx_state_r <= RDONE;
                if (rx_bad_r || (rx_a_r == rd_s)) begin
                  rx_err <= 1'b1;
                end else begin
                  rx_valid <= 1'b1;
                  rx_data  <= rx_next_s;
                end
              end else begin
                rx_bit_r <= rx_bit_r + BIT_ONE;
              end
            end
          end else begin
            rx_cnt_r <= rx_cnt_r - CNT_ONE;
          end
        end
        RDONE: begin
          rx_state_r <= RIDLE;
        end
        default: begin
          rx_state_r <= RIDLE;
        end
      endcase
    end
  end

endmodule
